// File: rtl/data_mem_responder.sv
// Single-port data-memory responder: accepts one request at a time, waits WAIT_CYCLES,
// then reports read data or an alignment/range error with a one-cycle strobe.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_WORDS   = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [31:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    mem_we;

  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

  // Full 30-bit word index is compared, so out-of-range addresses never alias into the array.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(MEM_WORDS));
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        // Response strobe is registered, so it appears in the cycle after RESP.
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        rsp_err_d   = addr_bad(addr_q);
        if (!we_q && !addr_bad(addr_q)) begin
          rsp_rdata_d = mem[addr_q[IdxW+1:2]];
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
    // The edge entering RESP commits the write; with zero wait states that is the accept edge.
    mem_we  = (state_d == StResp) && we_d && !addr_bad(addr_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array is not reset; a write is only committed while reset is high.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[addr_d[IdxW+1:2]] <= wdata_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table plus scoreboard, with a second
// zero-wait-state instance for back-to-back behaviour.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0 = 1'b0, req_we0 = 1'b0;
  logic [31:0] req_addr0 = '0, req_wdata0 = '0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  data_mem_responder #(.DATA_WIDTH(32), .MEM_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DATA_WIDTH(32), .MEM_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_we(req_we0), .req_addr(req_addr0),
    .req_wdata(req_wdata0), .req_ready(req_ready0), .rsp_valid(rsp_valid0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t q[$];
  exp_t q0[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboards: compare on each negedge where the DUT strobes a response.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_latency", 32'(cyc), 32'(e.due));
      end
    end else if (rsp_valid === 1'b0 && (rsp_rdata !== '0 || rsp_err !== 1'b0)) begin
      check("idle_rsp_quiet", {rsp_rdata[30:0], rsp_err}, 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid0 === 1'b1) begin
      if (q0.size() == 0) begin
        check("w0_unexpected_rsp_valid", {31'b0, rsp_valid0}, 32'd0);
      end else begin
        e = q0.pop_front();
        check("w0_rsp_rdata", rsp_rdata0, e.rdata);
        check("w0_rsp_err", {31'b0, rsp_err0}, {31'b0, e.err});
        check("w0_rsp_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q0.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(q.size() + q0.size()), 32'd0);
  endtask

  // Presents one request, waits (bounded) for acceptance, scrambles req_* afterwards.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = w;
    req_addr  = a;
    req_wdata = d;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_timeout", {31'b0, req_ready}, 32'd1);
    end else begin
      q.push_back('{rdata: er, err: ee, due: cyc + 4});
      @(posedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~w;
    req_addr  = 32'hFFFF_FFF0;
    req_wdata = 32'h0BAD_0BAD;
    drain();
  endtask

  initial begin
    int acc_cyc[$];

    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_000C, 32'h1111_1111, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_000C, 32'h0,         32'h1111_1111, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0100, 32'h0000_0055, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,         32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_00FC, 32'h1234_5678, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_00FC, 32'h0,         32'h1234_5678, 1'b0});
    vecs.push_back('{1'b0, 32'h4000_0010, 32'h0,         32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0110, 32'h0000_0099, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0002, 32'h7777_7777, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0});

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'd0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp", {rsp_rdata[30:0], rsp_err}, 32'd0);
    check("reset_ready_w0", {31'b0, req_ready0}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'b0, req_ready}, 32'd1);
    check("ready_after_reset_w0", {31'b0, req_ready0}, 32'd1);

    foreach (vecs[i]) do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);

    // Held req_valid: one accept every WAIT_CYCLES+2 = 4 cycles.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_000C;
    for (int i = 0; i < 16; i++) begin
      if (req_ready === 1'b1) begin
        acc_cyc.push_back(cyc);
        q.push_back('{rdata: 32'h1111_1111, err: 1'b0, due: cyc + 4});
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("held_accept_count", 32'(acc_cyc.size()), 32'd4);
    for (int i = 1; i < acc_cyc.size(); i++) begin
      check("held_accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
    end
    drain();

    // Reset during WAIT drops the pending write and its response.
    do_req(1'b1, 32'h0000_0020, 32'h0000_0001, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'hCAFE_F00D;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_reset_ready", {31'b0, req_ready}, 32'd0);
    check("abort_reset_rsp", {rsp_rdata[29:0], rsp_valid, rsp_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    do_req(1'b0, 32'h0000_0020, 32'h0, 32'h0000_0001, 1'b0);

    // Zero wait states: ready alternates, response one edge after each accept.
    @(negedge clk);
    req_valid0 = 1'b1;
    req_we0    = 1'b1;
    req_addr0  = 32'h0000_0004;
    req_wdata0 = 32'h0000_0077;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) req_we0 = 1'b0;
      check("w0_ready_pattern", {31'b0, req_ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (req_ready0 === 1'b1) begin
        q0.push_back('{rdata: req_we0 ? 32'h0 : 32'h0000_0077, err: 1'b0, due: cyc + 2});
      end
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    drain();

    repeat (4) @(negedge clk);
    check("final_queue_empty", 32'(q.size() + q0.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of request write data and response read data.
REQ-002 Parameter MEM_WORDS, default 64: number of DATA_WIDTH-bit words in the backing array.
REQ-003 Parameter WAIT_CYCLES, default 2: access wait states; legal range 0..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 req_valid  input  1  processor presents a data-memory request.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address; word index = req_addr[31:2].
REQ-009 req_wdata  input  DATA_WIDTH  store data.
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 rsp_valid  output  1  one-cycle response strobe.
REQ-012 rsp_rdata  output  DATA_WIDTH  load data; qualified by rsp_valid.
REQ-013 rsp_err  output  1  request was misaligned or out of range; qualified by rsp_valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-016 On accept, the block SHALL latch req_we, req_addr and req_wdata; later changes on req_* SHALL have no effect on that transaction.
REQ-017 Transitions from IDLE on accept: to WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES>=1; directly to RESP if WAIT_CYCLES=0.
REQ-018 In WAIT, the counter SHALL decrement each edge; at the edge where counter=0, the FSM SHALL go to RESP.
REQ-019 RESP SHALL last exactly one cycle, then return to IDLE; requests presented while not IDLE SHALL be ignored, not queued.
REQ-020 rsp_valid SHALL be 1 in the cycle that begins WAIT_CYCLES+1 rising edges after the accepting edge, and 0 in every other cycle.
REQ-021 Throughput SHALL be one transaction per WAIT_CYCLES+2 cycles when req_valid is held high.
REQ-022 Error condition: latched addr[1:0]!=0, or word index >= MEM_WORDS, gives rsp_err=1 and rsp_rdata=0 in RESP.
REQ-023 An erroring write SHALL NOT modify the array.
REQ-024 A valid write SHALL commit to the array on the edge entering RESP; in RESP, rsp_rdata=0 and rsp_err=0.
REQ-025 For a valid read, rsp_rdata SHALL equal the array word as of the edge entering RESP; a read after a write to the same word returns the new data.
REQ-026 When rsp_valid=0, rsp_rdata SHALL be 0 and rsp_err SHALL be 0.
REQ-027 Index arithmetic SHALL use the full 30-bit word index; the block SHALL NOT wrap or truncate an out-of-range index into range.

Reset
REQ-028 While reset=0, the block SHALL asynchronously force state=IDLE, counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-029 req_ready SHALL go to 1 in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-transaction SHALL abort it with no response; an uncommitted write SHALL be dropped.
REQ-031 Array contents SHALL NOT be cleared by reset; contents before the first write are undefined.

Verification
REQ-032 Write 0xDEADBEEF to addr 0x10, then read 0x10 (WAIT_CYCLES=2) -> each rsp_valid exactly 3 edges after accept; read gives rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-033 Read addr 0x13 -> rsp_err=1 and rsp_rdata=0; write 0x11111111 to 0x0C followed by read 0x0C -> 0x11111111.
REQ-034 Write 0x55 to addr 0x100 (MEM_WORDS=64) -> rsp_err=1; prior contents at 0x0 still read back intact.
REQ-035 Hold req_valid=1 continuously over 4 reads -> req_ready=1 once every 4 cycles; no request accepted while busy.
REQ-036 Assert reset during WAIT of write 0xCAFEF00D to 0x20, after a prior write of 0x1 to 0x20 -> no rsp_valid; after reset, read 0x20 -> 0x1.
REQ-037 WAIT_CYCLES=0, back-to-back reads -> rsp_valid one edge after each accept; req_ready alternates 1,0.
